// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable synchronous RAM.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ram_pkg;

  // Controller state: clearing the array after reset, or serving requests.
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  // Number of 8-bit write lanes in a data word.
  function automatic int byte_lanes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/ram_init_ctrl.sv
// Post-reset clear sequencer: walks every word once, writing zero, then hands over.
// Latency: DEPTH cycles from reset release to busy_o low (0 when INIT_CLEAR=0).
// Backpressure: none; busy_o tells the owner to drop requests while clearing.
// Ports: clk_i/rst_ni clock and async active-low reset; busy_o clear in progress;
//        clr_we_o/clr_addr_o zero-write strobe and word index for the memory port.
module ram_init_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int IW         = 10,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic          busy_o,
  output logic          clr_we_o,
  output logic [IW-1:0] clr_addr_o
);

  // Compare against the real last word, not the top of the address space.
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  ram_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT_CLEAR ? ST_INIT : ST_READY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    busy_o   = 1'b0;
    clr_we_o = 1'b0;
    case (state_q)
      ST_INIT: begin
        busy_o   = 1'b1;
        clr_we_o = 1'b1;
        if (ptr_q == LAST) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + IW'(1);
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  assign clr_addr_o = ptr_q;

endmodule

// File: rtl/ram_sync_be.sv
// Single-port synchronous RAM with per-byte write enables, registered read and request error flag.
// Latency: read data and rvalid one clock after the request edge; writes land at the request edge.
// Backpressure: none; requests while busy are dropped silently, illegal requests pulse err.
// Ports: clk/rst_n; cs/rd/wr/addr/wdata/be request; rdata/rvalid read return;
//        busy clear in progress; err one-cycle pulse for a conflict or out-of-range request.
module ram_sync_be
  import ram_pkg::*;
#(
  parameter int DW         = 32,
  parameter int DEPTH      = 1024,
  parameter int AW         = 10,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cs,
  input  logic            rd,
  input  logic            wr,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] be,
  output logic [DW-1:0]   rdata,
  output logic            rvalid,
  output logic            busy,
  output logic            err
);

  localparam int NB = byte_lanes(DW);
  // Array index width sized to DEPTH; addr may carry extra bits for range checking.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];

  logic          clr_we;
  logic [IW-1:0] clr_addr;
  logic [IW-1:0] idx;
  logic [31:0]   addr_ext;
  logic          in_range, req, rd_ok, wr_ok, bad;

  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;

  ram_init_ctrl #(
    .DEPTH      (DEPTH),
    .IW         (IW),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_init_ctrl (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign addr_ext = 32'(addr);
  assign in_range = addr_ext < 32'(DEPTH);
  assign idx      = addr[IW-1:0];

  // Requests while busy never reach decode, so they raise neither err nor rvalid.
  assign req   = cs && !busy && (rd || wr);
  assign rd_ok = req && rd && !wr && in_range;
  assign wr_ok = req && wr && !rd && in_range;
  assign bad   = req && !(rd_ok || wr_ok);

  // Clear and user writes never overlap: user writes are only accepted once busy drops.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rd_ok;
    err_d    = bad;
    if (rd_ok) begin
      rdata_d = mem[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_ram_sync_be.sv
// Self-checking bench for ram_sync_be (DEPTH=16) against a word-array reference model.
// Latency: model predicts outputs one clock after each request edge.
// Backpressure: model drops every request during the DEPTH-cycle clear window.
module tb_ram_sync_be;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 5;

  logic          clk;
  logic          rst_n;
  logic          cs, rd, wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    be;
  logic [DW-1:0] rdata;
  logic          rvalid, busy, err;

  ram_sync_be #(
    .DW         (DW),
    .DEPTH      (DEPTH),
    .AW         (AW),
    .INIT_CLEAR (1'b1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cs     (cs),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .be     (be),
    .rdata  (rdata),
    .rvalid (rvalid),
    .busy   (busy),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  logic [31:0] m_mem [DEPTH];
  int          m_busy;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request cycle: drive at negedge, model at posedge, compare at next negedge.
  task automatic cyc(input logic c, input logic r, input logic w, input logic [4:0] a,
                     input logic [31:0] d, input logic [3:0] b);
    cs = c; rd = r; wr = w; addr = a; wdata = d; be = b;
    @(posedge clk);
    m_rvalid = 1'b0;
    m_err    = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
    end else if (c && (r || w)) begin
      if ((r && w) || int'(a) >= DEPTH) begin
        m_err = 1'b1;
      end else if (w) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) m_mem[a[3:0]][i*8 +: 8] = d[i*8 +: 8];
      end else begin
        m_rdata  = m_mem[a[3:0]];
        m_rvalid = 1'b1;
      end
    end
    @(negedge clk);
    chk("busy",   32'(busy),   32'(m_busy > 0));
    chk("rvalid", 32'(rvalid), 32'(m_rvalid));
    chk("err",    32'(err),    32'(m_err));
    chk("rdata",  rdata,       m_rdata);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
  endtask

  // Called at a negedge; checks that reset acts without waiting for a clock edge.
  task automatic do_reset(input int hold);
    #1 rst_n = 1'b0;
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    #1;
    chk("rst_rdata",  rdata,        32'd0);
    chk("rst_rvalid", 32'(rvalid),  32'd0);
    chk("rst_err",    32'(err),     32'd0);
    chk("rst_busy",   32'(busy),    32'd1);
    repeat (hold) @(negedge clk);
    rst_n    = 1'b1;
    m_busy   = DEPTH;
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_err    = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  // Runs the clear window with junk requests; abort_at >= 0 stops early for a mid-clear reset.
  task automatic clear_phase(input int abort_at);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      if (abort_at >= 0 && cnt == abort_at) return;
      if (cnt == 10)
        cyc(1'b1, 1'b0, 1'b1, 5'd3, 32'hFFFF_FFFF, 4'hF);
      else
        cyc(1'b1, 1'($urandom % 2), 1'($urandom % 2), 5'($urandom_range(0, 20)),
            $urandom, 4'($urandom % 16));
      cnt++;
    end
    if (abort_at < 0) chk("clear_len", 32'(cnt), 32'(DEPTH));
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, 1'b0, 5'(i), 32'd0, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = '0; wdata = '0; be = '0;
    m_busy = 0; m_rdata = '0; m_rvalid = 1'b0; m_err = 1'b0;
    @(negedge clk);

    // Power-up clear, including a dropped write to addr 3 mid-clear.
    do_reset(3);
    clear_phase(-1);
    read_all();

    // Byte-enable merge.
    cyc(1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 4'b1111);
    cyc(1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_AA00, 4'b0010);
    cyc(1'b1, 1'b1, 1'b0, 5'd5, 32'd0, 4'd0);
    chk("be_merge", rdata, 32'hDEAD_AAEF);
    idle();
    cyc(1'b1, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 4'b0000);
    cyc(1'b1, 1'b1, 1'b0, 5'd5, 32'd0, 4'd0);

    // Preload and back-to-back reads.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, 5'(i), 32'(i * 17), 4'hF);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 5'(i), 32'd0, 4'd0);

    // Conflict, out of range, deselected.
    cyc(1'b1, 1'b1, 1'b1, 5'd2, 32'hCAFE_F00D, 4'hF);
    cyc(1'b1, 1'b1, 1'b0, 5'd2, 32'd0, 4'd0);
    cyc(1'b1, 1'b1, 1'b0, 5'd16, 32'd0, 4'd0);
    cyc(1'b1, 1'b0, 1'b1, 5'd31, 32'h5555_5555, 4'hF);
    cyc(1'b0, 1'b1, 1'b0, 5'd1, 32'd0, 4'd0);
    cyc(1'b0, 1'b0, 1'b1, 5'd1, 32'hAAAA_AAAA, 4'hF);
    cyc(1'b1, 1'b1, 1'b0, 5'd1, 32'd0, 4'd0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      logic c, r, w;
      logic [4:0] a;
      logic [3:0] b;
      logic [31:0] d;
      c = ($urandom_range(0, 3) != 0);
      r = 1'($urandom % 2);
      w = 1'($urandom % 2);
      a = 5'($urandom_range(0, 20));
      b = 4'($urandom % 16);
      d = $urandom;
      cyc(c, r, w, a, d, b);
    end

    // Reset in the middle of traffic with nonzero rdata.
    cyc(1'b1, 1'b0, 1'b1, 5'd1, 32'h1234_5678, 4'hF);
    cyc(1'b1, 1'b1, 1'b0, 5'd1, 32'd0, 4'd0);
    do_reset(2);
    clear_phase(-1);

    // Reset at clear cycle 7, then a full fresh clear.
    cyc(1'b1, 1'b0, 1'b1, 5'd9, 32'h0BAD_0BAD, 4'hF);
    do_reset(2);
    clear_phase(7);
    do_reset(2);
    clear_phase(-1);
    read_all();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ram_sync_be.md
Name: ram_sync_be

Overview:
- Parametrised single-port synchronous RAM with separate write-data and read-data buses (no inout or tristate).
- Adds per-byte write enables, a registered read with a valid strobe, a post-reset clear state machine, and error flagging for illegal requests.
- Used as the general on-chip data/scratch memory in processorDesign; it replaces ad-hoc fixed 1K×8 RAM models.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- DEPTH, 1024, number of words; need not be a power of two.
- AW, 10, address width; must satisfy 2**AW >= DEPTH.
- INIT_CLEAR, 1, 1 = zero every word after reset; 0 = skip clearing (contents undefined).

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- cs, input, 1, chip select; request is qualified only when cs=1.
- rd, input, 1, read request.
- wr, input, 1, write request.
- addr, input, AW, word address.
- wdata, input, DW, write data.
- be, input, DW/8, byte enables; bit i covers wdata[8i+7:8i].
- rdata, output, DW, registered read data.
- rvalid, output, 1, one-cycle pulse: rdata is updated this cycle.
- busy, output, 1, clear in progress; requests are ignored.
- err, output, 1, one-cycle pulse for a rejected request.

Behaviour:
- Reset (rst_n=0, takes effect asynchronously): rdata=0, rvalid=0, err=0, busy=INIT_CLEAR, FSM enters INIT if INIT_CLEAR=1, otherwise READY.
- FSM states: INIT, READY.
- INIT:
  - Internal counter ptr starts at 0.
  - Each cycle writes 0 to mem[ptr] and increments ptr.
  - In the cycle ptr==DEPTH-1 is written, go to READY.
  - busy deasserts on the first READY cycle. A full clear takes exactly DEPTH cycles after rst_n rises.
  - Requests arriving while busy=1 are dropped silently: no err, no rvalid, no memory change.
- READY, request qualified at posedge when cs=1 and busy=0:
  - Write (wr=1, rd=0, addr<DEPTH): for each i with be[i]=1, mem[addr] byte i <= wdata byte i; bytes with be[i]=0 are unchanged. be=0 is a legal no-op. rdata and rvalid are unaffected.
  - Read (rd=1, wr=0, addr<DEPTH): rdata <= mem[addr] at the same edge, and rvalid=1 for the following cycle. Read latency is 1 clock. Back-to-back reads every cycle are supported, with rvalid held high continuously.
  - Conflict (rd=1 and wr=1): no access; err=1 for one cycle; rdata holds its value.
  - Out of range (addr>=DEPTH with rd or wr): no access; err=1 for one cycle; rvalid=0.
  - cs=0, or rd=wr=0: idle. rvalid=0, err=0, rdata holds.
- Read after write to the same address on the next cycle returns the new data; there is no read-during-write case because the port is single.
- rdata holds its last value between reads and is never forced to 0 except by reset.
- Reset mid-INIT or mid-operation:
  - Aborts everything; ptr=0.
  - With INIT_CLEAR=1 the clear restarts from 0 after rst_n rises.
  - A write in flight at the reset edge is not guaranteed.
- Addresses wrap nowhere: the counter compares to DEPTH-1, not 2**AW-1.

Decomposition:
- Package ram_pkg:
  - State encoding constants ST_INIT and ST_READY.
  - Localparam helper for byte-lane count (DW/8).
- Sub-module ram_init_ctrl: the INIT/READY FSM plus the clear counter. It outputs busy, clr_we and clr_addr, which the top muxes onto the memory write port.

Test Plan:
- DEPTH=16, INIT_CLEAR=1: release rst_n -> busy=1 for exactly 16 cycles; a write to addr 3 issued during busy is ignored; afterwards, reading all 16 addresses returns 0x00000000 with rvalid one cycle after each request.
- Write 0xDEADBEEF to addr 5 with be=4'b1111, then be=4'b0010 with wdata 0x0000AA00 -> reading addr 5 returns 0xDEADAAEF one cycle later, rvalid=1 for one cycle.
- Read addresses 0..7 on consecutive cycles (preloaded value = addr×0x11) -> rvalid high for 8 consecutive cycles; rdata sequence 0x00, 0x11 … 0x77.
- rd=1 and wr=1 with cs=1 at addr 2 -> err pulses one cycle; mem[2] unchanged; rdata unchanged. Then addr=16 read with DEPTH=16 -> err=1, rvalid=0.
- cs=0 with rd=1 -> no rvalid, no err.
- Assert rst_n=0 at clear cycle 7, hold 2 cycles, release -> outputs go to reset values immediately; busy stays 1 for a full 16 further cycles; all words read back 0.
